// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register.
// Captures the decoded control word and operands from the decode stage and
// presents them to the EX stage one cycle later. Flush beats stall beats load.
// An invalid slot (ValidD=0) still loads, but its side-effect controls are
// forced to zero so a bubble can never write registers or memory.
// Optional build macro: ID_EX_PERF_EN adds saturating BubbleCnt/StallCnt.
module id_ex_pipe_reg #(
  parameter int XLEN  = 32,
  parameter int RAW   = 5
`ifdef ID_EX_PERF_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            StallE,
  input  logic            FlushE,
  input  logic            ValidD,
  input  logic            RegWriteD,
  input  logic            MemWriteD,
  input  logic            JumpD,
  input  logic            BranchD,
  input  logic            JalrD,
  input  logic            ALUSrcD,
  input  logic [1:0]      ResultSrcD,
  input  logic [2:0]      ALUControlD,
  input  logic [2:0]      Funct3D,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic [RAW-1:0]  Rs1D,
  input  logic [RAW-1:0]  Rs2D,
  input  logic [RAW-1:0]  RdD,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            JalrE,
  output logic            ALUSrcE,
  output logic [1:0]      ResultSrcE,
  output logic [2:0]      ALUControlE,
  output logic [2:0]      Funct3E,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [RAW-1:0]  Rs1E,
  output logic [RAW-1:0]  Rs2E,
  output logic [RAW-1:0]  RdE,
  output logic            ValidE
`ifdef ID_EX_PERF_EN
  ,
  output logic [CNT_W-1:0] BubbleCnt,
  output logic [CNT_W-1:0] StallCnt
`endif
);

  // All-zero word is the NOP bubble, so reset and flush share one encoding.
  typedef struct packed {
    logic            reg_write;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic            jalr;
    logic            alu_src;
    logic [1:0]      result_src;
    logic [2:0]      alu_control;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [RAW-1:0]  rs1;
    logic [RAW-1:0]  rs2;
    logic [RAW-1:0]  rd;
    logic            valid;
  } ex_word_t;

  ex_word_t r_word;
  ex_word_t w_load;
  ex_word_t w_next;

  // Build the word to load from D, masking side-effect controls of invalid slots.
  always_comb begin
    w_load             = '0;
    w_load.reg_write   = RegWriteD & ValidD;
    w_load.mem_write   = MemWriteD & ValidD;
    w_load.jump        = JumpD     & ValidD;
    w_load.branch      = BranchD   & ValidD;
    w_load.jalr        = JalrD     & ValidD;
    w_load.alu_src     = ALUSrcD;
    w_load.result_src  = ResultSrcD;
    w_load.alu_control = ALUControlD;
    w_load.funct3      = Funct3D;
    w_load.rd1         = RD1D;
    w_load.rd2         = RD2D;
    w_load.imm_ext     = ImmExtD;
    w_load.pc          = PCD;
    w_load.pc_plus4    = PCPlus4D;
    w_load.rs1         = Rs1D;
    w_load.rs2         = Rs2D;
    w_load.rd          = RdD;
    w_load.valid       = ValidD;
  end

  // Select next E contents: flush wins over stall, stall wins over load.
  always_comb begin
    w_next = w_load;
    if (FlushE) begin
      w_next = '0;
    end else if (StallE) begin
      w_next = r_word;
    end else begin
      w_next = w_load;
    end
  end

  // E-stage register with asynchronous clear to the bubble word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
    end else begin
      r_word <= w_next;
    end
  end

  assign RegWriteE   = r_word.reg_write;
  assign MemWriteE   = r_word.mem_write;
  assign JumpE       = r_word.jump;
  assign BranchE     = r_word.branch;
  assign JalrE       = r_word.jalr;
  assign ALUSrcE     = r_word.alu_src;
  assign ResultSrcE  = r_word.result_src;
  assign ALUControlE = r_word.alu_control;
  assign Funct3E     = r_word.funct3;
  assign RD1E        = r_word.rd1;
  assign RD2E        = r_word.rd2;
  assign ImmExtE     = r_word.imm_ext;
  assign PCE         = r_word.pc;
  assign PCPlus4E    = r_word.pc_plus4;
  assign Rs1E        = r_word.rs1;
  assign Rs2E        = r_word.rs2;
  assign RdE         = r_word.rd;
  assign ValidE      = r_word.valid;

`ifdef ID_EX_PERF_EN
  logic [CNT_W-1:0] r_bubble_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Count flush bubbles and effective stall cycles (a stall under flush is not a stall).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubble_cnt <= '0;
      r_stall_cnt  <= '0;
    end else begin
      if (FlushE) begin
        r_bubble_cnt <= sat_inc(r_bubble_cnt);
      end else begin
        r_bubble_cnt <= r_bubble_cnt;
      end
      if (StallE && !FlushE) begin
        r_stall_cnt <= sat_inc(r_stall_cnt);
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
    end
  end

  assign BubbleCnt = r_bubble_cnt;
  assign StallCnt  = r_stall_cnt;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed table, reset/saturation
// sequences and randomized traffic against a reference model of the E stage.
module tb_id_ex_pipe_reg;

`ifdef ID_EX_PERF_EN
  localparam int CW = 4;
`endif

  typedef struct packed {
    logic        flush, stall, valid, regw, memw, jump, branch, jalr, alusrc;
    logic [1:0]  rsrc;
    logic [2:0]  aluc, f3;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
  } vin_t;

  typedef struct {
    vin_t        in;
    logic        e_valid, e_regw, e_memw, e_branch, e_jump;
    logic [1:0]  e_rsrc;
    logic [2:0]  e_aluc;
    logic [31:0] e_rd2;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic StallE, FlushE, ValidD, RegWriteD, MemWriteD, JumpD, BranchD, JalrD, ALUSrcD;
  logic [1:0]  ResultSrcD;
  logic [2:0]  ALUControlD, Funct3D;
  logic [31:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic RegWriteE, MemWriteE, JumpE, BranchE, JalrE, ALUSrcE, ValidE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE, Funct3E;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;
`ifdef ID_EX_PERF_EN
  logic [CW-1:0] BubbleCnt, StallCnt;
`endif

  id_ex_pipe_reg #(
    .XLEN(32), .RAW(5)
`ifdef ID_EX_PERF_EN
    , .CNT_W(CW)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
    .JalrD(JalrD), .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
    .Funct3D(Funct3D), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .JalrE(JalrE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .Funct3E(Funct3E), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ValidE(ValidE)
`ifdef ID_EX_PERF_EN
    , .BubbleCnt(BubbleCnt), .StallCnt(StallCnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the E-stage contents as the bench believes them to be,
  // kept in the same record layout as the stimulus (flush/stall bits unused).
  vin_t m;
  int   n_bubble = 0;
  int   n_stall  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic check_model();
    chk("ValidE", {31'd0, ValidE}, {31'd0, m.valid});
    chk("RegWriteE", {31'd0, RegWriteE}, {31'd0, m.regw});
    chk("MemWriteE", {31'd0, MemWriteE}, {31'd0, m.memw});
    chk("JumpE", {31'd0, JumpE}, {31'd0, m.jump});
    chk("BranchE", {31'd0, BranchE}, {31'd0, m.branch});
    chk("JalrE", {31'd0, JalrE}, {31'd0, m.jalr});
    chk("ALUSrcE", {31'd0, ALUSrcE}, {31'd0, m.alusrc});
    chk("ResultSrcE", {30'd0, ResultSrcE}, {30'd0, m.rsrc});
    chk("ALUControlE", {29'd0, ALUControlE}, {29'd0, m.aluc});
    chk("Funct3E", {29'd0, Funct3E}, {29'd0, m.f3});
    chk("RD1E", RD1E, m.rd1);
    chk("RD2E", RD2E, m.rd2);
    chk("ImmExtE", ImmExtE, m.imm);
    chk("PCE", PCE, m.pc);
    chk("PCPlus4E", PCPlus4E, m.pc4);
    chk("Rs1E", {27'd0, Rs1E}, {27'd0, m.rs1});
    chk("Rs2E", {27'd0, Rs2E}, {27'd0, m.rs2});
    chk("RdE", {27'd0, RdE}, {27'd0, m.rd});
`ifdef ID_EX_PERF_EN
    chk("BubbleCnt", {{(32-CW){1'b0}}, BubbleCnt}, sat(n_bubble, CW));
    chk("StallCnt", {{(32-CW){1'b0}}, StallCnt}, sat(n_stall, CW));
`endif
  endtask

  task automatic drive(input vin_t v);
    FlushE = v.flush; StallE = v.stall; ValidD = v.valid; RegWriteD = v.regw;
    MemWriteD = v.memw; JumpD = v.jump; BranchD = v.branch; JalrD = v.jalr;
    ALUSrcD = v.alusrc; ResultSrcD = v.rsrc; ALUControlD = v.aluc; Funct3D = v.f3;
    RD1D = v.rd1; RD2D = v.rd2; ImmExtD = v.imm; PCD = v.pc; PCPlus4D = v.pc4;
    Rs1D = v.rs1; Rs2D = v.rs2; RdD = v.rd;
  endtask

  // One clock edge: drive at negedge, advance the model at posedge, compare #1 later.
  task automatic apply(input vin_t v);
    @(negedge clk);
    rst_n = 1'b1;
    drive(v);
    @(posedge clk);
    if (v.flush) begin
      m = '0;
      n_bubble++;
    end else if (v.stall) begin
      n_stall++;
    end else begin
      m = v;
      m.flush = 1'b0;
      m.stall = 1'b0;
      if (!v.valid) begin
        m.regw = 1'b0; m.memw = 1'b0; m.jump = 1'b0; m.branch = 1'b0; m.jalr = 1'b0;
      end
    end
    #1;
    check_model();
  endtask

  // Async reset mid-cycle with all-ones D inputs; outputs must clear with no edge.
  task automatic async_reset();
    vin_t ones;
    ones = '1;
    ones.flush = 1'b0;
    ones.stall = 1'b0;
    @(negedge clk);
    drive(ones);
    #2;
    rst_n = 1'b0;
    #1;
    m = '0;
    n_bubble = 0;
    n_stall = 0;
    check_model();
    @(posedge clk);
    #1;
    check_model();
  endtask

  function automatic vin_t rand_vin();
    vin_t v;
    v = '0;
    v.flush  = ($urandom_range(0, 7) == 0);
    v.stall  = ($urandom_range(0, 3) == 0);
    v.valid  = ($urandom_range(0, 4) != 0);
    v.regw   = 1'($urandom); v.memw = 1'($urandom); v.jump = 1'($urandom);
    v.branch = 1'($urandom); v.jalr = 1'($urandom); v.alusrc = 1'($urandom);
    v.rsrc   = 2'($urandom); v.aluc = 3'($urandom); v.f3 = 3'($urandom);
    v.rd1 = $urandom; v.rd2 = $urandom; v.imm = $urandom; v.pc = $urandom;
    v.pc4 = v.pc + 32'd4;
    v.rs1 = 5'($urandom); v.rs2 = 5'($urandom); v.rd = 5'($urandom);
    return v;
  endfunction

  vec_t tv[8];
  vin_t z;

  initial begin
    // Directed table: pass-through, lw under 3 stalls, jal, flush+stall, invalid slot.
    z = '0;
    for (int i = 0; i < 8; i++) tv[i].in = z;
    tv[0].in.valid = 1'b1; tv[0].in.regw = 1'b1; tv[0].in.aluc = 3'b001;
    tv[0].in.rd1 = 32'h5; tv[0].in.rd2 = 32'h3; tv[0].in.rd = 5'd7;
    tv[0].e_valid = 1'b1; tv[0].e_regw = 1'b1; tv[0].e_memw = 1'b0; tv[0].e_branch = 1'b0;
    tv[0].e_jump = 1'b0; tv[0].e_rsrc = 2'b00; tv[0].e_aluc = 3'b001; tv[0].e_rd2 = 32'h3;
    tv[1].in.valid = 1'b1; tv[1].in.regw = 1'b1; tv[1].in.rsrc = 2'b01; tv[1].in.alusrc = 1'b1;
    tv[1].in.rd1 = 32'h100; tv[1].in.imm = 32'h8; tv[1].in.rd = 5'd9; tv[1].in.rs1 = 5'd2;
    tv[1].e_valid = 1'b1; tv[1].e_regw = 1'b1; tv[1].e_memw = 1'b0; tv[1].e_branch = 1'b0;
    tv[1].e_jump = 1'b0; tv[1].e_rsrc = 2'b01; tv[1].e_aluc = 3'b000; tv[1].e_rd2 = 32'h0;
    for (int i = 2; i < 5; i++) begin
      tv[i].in.stall = 1'b1; tv[i].in.valid = 1'b1; tv[i].in.memw = 1'b1;
      tv[i].in.aluc = 3'b010; tv[i].in.rd2 = 32'hDEAD_0000 + i;
      tv[i].e_valid = 1'b1; tv[i].e_regw = 1'b1; tv[i].e_memw = 1'b0; tv[i].e_branch = 1'b0;
      tv[i].e_jump = 1'b0; tv[i].e_rsrc = 2'b01; tv[i].e_aluc = 3'b000; tv[i].e_rd2 = 32'h0;
    end
    tv[5].in.valid = 1'b1; tv[5].in.jump = 1'b1; tv[5].in.regw = 1'b1; tv[5].in.rsrc = 2'b10;
    tv[5].in.pc = 32'h40; tv[5].in.pc4 = 32'h44; tv[5].in.rd = 5'd1;
    tv[5].e_valid = 1'b1; tv[5].e_regw = 1'b1; tv[5].e_memw = 1'b0; tv[5].e_branch = 1'b0;
    tv[5].e_jump = 1'b1; tv[5].e_rsrc = 2'b10; tv[5].e_aluc = 3'b000; tv[5].e_rd2 = 32'h0;
    tv[6].in = tv[0].in; tv[6].in.flush = 1'b1; tv[6].in.stall = 1'b1;
    tv[6].e_valid = 1'b0; tv[6].e_regw = 1'b0; tv[6].e_memw = 1'b0; tv[6].e_branch = 1'b0;
    tv[6].e_jump = 1'b0; tv[6].e_rsrc = 2'b00; tv[6].e_aluc = 3'b000; tv[6].e_rd2 = 32'h0;
    tv[7].in.valid = 1'b0; tv[7].in.memw = 1'b1; tv[7].in.branch = 1'b1; tv[7].in.regw = 1'b1;
    tv[7].in.jump = 1'b1; tv[7].in.rd2 = 32'hABCD;
    tv[7].e_valid = 1'b0; tv[7].e_regw = 1'b0; tv[7].e_memw = 1'b0; tv[7].e_branch = 1'b0;
    tv[7].e_jump = 1'b0; tv[7].e_rsrc = 2'b00; tv[7].e_aluc = 3'b000; tv[7].e_rd2 = 32'hABCD;

    drive(z);
    m = '0;
    #1;
    check_model();   // power-on reset state, before any clock edge

    for (int i = 0; i < 8; i++) begin
      apply(tv[i].in);
      chk($sformatf("tv%0d.ValidE", i), {31'd0, ValidE}, {31'd0, tv[i].e_valid});
      chk($sformatf("tv%0d.RegWriteE", i), {31'd0, RegWriteE}, {31'd0, tv[i].e_regw});
      chk($sformatf("tv%0d.MemWriteE", i), {31'd0, MemWriteE}, {31'd0, tv[i].e_memw});
      chk($sformatf("tv%0d.BranchE", i), {31'd0, BranchE}, {31'd0, tv[i].e_branch});
      chk($sformatf("tv%0d.JumpE", i), {31'd0, JumpE}, {31'd0, tv[i].e_jump});
      chk($sformatf("tv%0d.ResultSrcE", i), {30'd0, ResultSrcE}, {30'd0, tv[i].e_rsrc});
      chk($sformatf("tv%0d.ALUControlE", i), {29'd0, ALUControlE}, {29'd0, tv[i].e_aluc});
      chk($sformatf("tv%0d.RD2E", i), RD2E, tv[i].e_rd2);
`ifdef ID_EX_PERF_EN
      if (i == 4) chk("stall3.StallCnt", {{(32-CW){1'b0}}, StallCnt}, 32'd3);
      if (i == 6) begin
        chk("flush.BubbleCnt", {{(32-CW){1'b0}}, BubbleCnt}, 32'd1);
        chk("flush.StallCnt", {{(32-CW){1'b0}}, StallCnt}, 32'd3);
      end
`endif
    end

    // Mid-stream async reset; first post-reset edge must load normally.
    async_reset();
    apply(tv[0].in);

    // Randomized traffic with one more reset in the middle.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) async_reset();
      apply(rand_vin());
    end

    // Long flush run: outputs stay a bubble and the bubble counter saturates.
    for (int i = 0; i < 20; i++) begin
      z = rand_vin();
      z.flush = 1'b1;
      apply(z);
    end
`ifdef ID_EX_PERF_EN
    chk("sat.BubbleCnt", {{(32-CW){1'b0}}, BubbleCnt}, 32'hF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
